// File: rtl/row_mem_feeder_if.sv
// row_mem_feeder_if: loader write port, MAC-side control and read-data bundle.
//   master: loader/MAC side drives wr_*, start, rd_bank, row_len, stop, need
//           and observes mem_data, mem_en, row_wrap, busy.
//   slave : the row_mem_feeder.
interface row_mem_feeder_if #(
    parameter int unsigned DATA_BW = 8,
    parameter int unsigned ADDR_W  = 7
);
    logic                 wr_en;
    logic                 wr_bank;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_BW-1:0]   wr_data;
    logic                 start;
    logic                 rd_bank;
    logic [ADDR_W:0]      row_len;
    logic                 stop;
    logic                 need;
    logic [DATA_BW-1:0]   mem_data;
    logic                 mem_en;
    logic                 row_wrap;
    logic                 busy;

    modport master (
        output wr_en, wr_bank, wr_addr, wr_data,
        output start, rd_bank, row_len, stop, need,
        input  mem_data, mem_en, row_wrap, busy
    );

    modport slave (
        input  wr_en, wr_bank, wr_addr, wr_data,
        input  start, rd_bank, row_len, stop, need,
        output mem_data, mem_en, row_wrap, busy
    );
endinterface

// File: rtl/row_mem_feeder.sv
// row_mem_feeder: double-banked row buffer feeding the MAC core.
// The loader writes one bank while the other is read. After start the block
// primes PRIME_CNT words (mem_en high), then returns one word per need pulse,
// with data valid two cycles after the request.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : wr_en/wr_bank/wr_addr/wr_data write port (always active),
//                 start/rd_bank/row_len/stop/need control,
//                 mem_data (registered), mem_en (registered),
//                 row_wrap (same-cycle pulse on the read at row_len-1),
//                 busy (registered, high outside IDLE)
module row_mem_feeder #(
    parameter int unsigned DATA_BW   = 8,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned PRIME_CNT = 3
) (
    input  logic            clk,
    input  logic            resetn,
    row_mem_feeder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = (PRIME_CNT > 1) ? $clog2(PRIME_CNT) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, SERVE} state_t;

    state_t              state_q, state_d;
    logic [DATA_BW-1:0]  mem [2][DEPTH];
    logic                rd_bank_q;
    logic [ADDR_W-1:0]   last_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]    prime_cnt_q;
    logic                need_q;
    logic [DATA_BW-1:0]  mem_data_q;
    logic                mem_en_q;
    logic                busy_q;

    logic                start_acc;
    logic                read_fire;
    logic                row_wrap_c;
    logic [ADDR_W-1:0]   row_last_c;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state, read strobe and wrap detection; stop overrides everything
    always_comb begin
        state_d    = state_q;
        start_acc  = 1'b0;
        read_fire  = 1'b0;
        row_wrap_c = 1'b0;
        // Lengths beyond the bank depth clamp to the full bank
        row_last_c = bus.row_len[ADDR_W] ? '1 : bus.row_len[ADDR_W-1:0] - ADDR_W'(1);
        case (state_q)
            IDLE: begin
                if (bus.start && (bus.row_len != '0)) begin
                    start_acc = 1'b1;
                    state_d   = PRIME;
                end
            end
            PRIME: begin
                read_fire = 1'b1;
                if (prime_cnt_q == CNT_W'(PRIME_CNT - 1)) state_d = SERVE;
            end
            SERVE: begin
                read_fire = need_q;
            end
            default: state_d = IDLE;
        endcase
        if (bus.stop) begin
            state_d   = IDLE;
            start_acc = 1'b0;
            read_fire = 1'b0;
        end
        row_wrap_c = read_fire && (rd_ptr_q == last_q);
    end

    // Datapath: session latch, read pointer, need delay and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_bank_q   <= 1'b0;
            last_q      <= '0;
            rd_ptr_q    <= '0;
            prime_cnt_q <= '0;
            need_q      <= 1'b0;
            mem_data_q  <= '0;
            mem_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            need_q   <= bus.need && (state_q == SERVE) && !bus.stop;
            mem_en_q <= (state_d == PRIME);
            busy_q   <= (state_d != IDLE);
            if (start_acc) begin
                rd_bank_q   <= bus.rd_bank;
                last_q      <= row_last_c;
                rd_ptr_q    <= '0;
                prime_cnt_q <= '0;
            end else if (read_fire) begin
                // Nonblocking read of the array gives read-first behaviour
                mem_data_q <= mem[rd_bank_q][rd_ptr_q];
                rd_ptr_q   <= row_wrap_c ? '0 : rd_ptr_q + ADDR_W'(1);
                if (state_q == PRIME) prime_cnt_q <= prime_cnt_q + CNT_W'(1);
            end
        end
    end

    // Bank storage: write port is live in every state and during reset
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
    end

    assign bus.mem_data = mem_data_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.busy     = busy_q;
    // Combinational so the pulse lands in the read cycle itself
    assign bus.row_wrap = row_wrap_c;

endmodule

// File: tb/tb_row_mem_feeder.sv
// tb_row_mem_feeder: directed scenarios plus random traffic for row_mem_feeder,
// checked every cycle against a cycle-schedule reference model.
module tb_row_mem_feeder;
    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int P     = 3;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    row_mem_feeder_if #(.DATA_BW(DW), .ADDR_W(AW)) bus ();

    row_mem_feeder #(.DATA_BW(DW), .ADDR_W(AW), .PRIME_CNT(P)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a session starts at cycle m_s, reads are scheduled
    // by cycle number, and a shadow copy of both banks supplies the data.
    bit             m_act = 1'b0;
    int             m_s = 0;
    int             m_len = 1;
    int             m_ptr = 0;
    bit             m_bank = 1'b0;
    logic [DW-1:0]  m_data = '0;
    logic [DW-1:0]  sm [2][DEPTH];
    bit             sched [16];

    always @(negedge clk) begin : model
        bit rd;
        bit e_en;
        bit e_wrap;
        if (!resetn) begin
            m_act  = 1'b0;
            m_data = '0;
            foreach (sched[k]) sched[k] = 1'b0;
            chk("rst_mem_data", int'(bus.mem_data), 0);
            chk("rst_mem_en", int'(bus.mem_en), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_row_wrap", int'(bus.row_wrap), 0);
        end else begin
            rd = sched[cyc % 16] && !bus.stop;
            sched[cyc % 16] = 1'b0;
            e_en   = m_act && (cyc >= m_s + 1) && (cyc <= m_s + P);
            e_wrap = rd && (m_ptr == m_len - 1);
            chk("mem_data", int'(bus.mem_data), int'(m_data));
            chk("mem_en", int'(bus.mem_en), e_en ? 1 : 0);
            chk("busy", int'(bus.busy), m_act ? 1 : 0);
            chk("row_wrap", int'(bus.row_wrap), e_wrap ? 1 : 0);
            if (rd) begin
                m_data = sm[m_bank][m_ptr];
                m_ptr  = (m_ptr + 1) % m_len;
            end
            if (bus.stop) begin
                m_act = 1'b0;
                foreach (sched[k]) sched[k] = 1'b0;
            end else if (!m_act && bus.start && (bus.row_len != 0)) begin
                m_act  = 1'b1;
                m_s    = cyc;
                m_bank = bus.rd_bank;
                m_len  = (int'(bus.row_len) > DEPTH) ? DEPTH : int'(bus.row_len);
                m_ptr  = 0;
                for (int k = 1; k <= P; k++) sched[(cyc + k) % 16] = 1'b1;
            end else if (m_act && (cyc >= m_s + P + 1) && bus.need) begin
                sched[(cyc + 1) % 16] = 1'b1;
            end
        end
        if (bus.wr_en) sm[bus.wr_bank][bus.wr_addr] = bus.wr_data;
    end

    // Advance one cycle; inputs default to inactive for the new cycle
    task automatic step();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.need  = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Background bank0 write for the ping-pong scenario
    task automatic wr_bank0();
        bus.wr_en   = 1'b1;
        bus.wr_bank = 1'b0;
        bus.wr_addr = AW'($urandom_range(8, DEPTH - 1));
        bus.wr_data = DW'($urandom);
    endtask

    logic [DW-1:0] lit [4];

    initial begin
        lit[0] = 8'd5;
        lit[1] = 8'hFD;
        lit[2] = 8'd7;
        lit[3] = 8'd42;
        bus.wr_en   = 1'b0;
        bus.wr_bank = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.rd_bank = 1'b0;
        bus.row_len = '0;
        bus.stop    = 1'b0;
        bus.need    = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Preload both banks
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                step();
                bus.wr_en   = 1'b1;
                bus.wr_bank = b[0];
                bus.wr_addr = AW'(a);
                if (b == 0 && a < 4)       bus.wr_data = lit[a];
                else if (b == 1 && a == 3) bus.wr_data = 8'h11;
                else                       bus.wr_data = DW'($urandom);
            end
        end

        // Prime path and serve latency, start in cycle 0
        step(); bus.rd_bank = 1'b0; bus.row_len = 8'd16; bus.start = 1'b1;
        @(negedge clk) chk("prime_busy_c0", int'(bus.busy), 0);
        step();
        @(negedge clk) chk("prime_en_c1", int'(bus.mem_en), 1);
        chk("prime_busy_c1", int'(bus.busy), 1);
        for (int k = 2; k <= 4; k++) begin
            step();
            @(negedge clk) chk("prime_data", int'(bus.mem_data), int'(lit[k - 2]));
            chk("prime_en", int'(bus.mem_en), (k <= 3) ? 1 : 0);
        end
        idle(5);
        step(); bus.need = 1'b1;
        step();
        step();
        @(negedge clk) chk("serve_data_c12", int'(bus.mem_data), 42);
        chk("serve_en_c12", int'(bus.mem_en), 0);
        step();
        @(negedge clk) chk("serve_hold_c13", int'(bus.mem_data), 42);
        step(); bus.stop = 1'b1;
        step();

        // Burst with wrap: row_len=4, need in cycles 5..7 reads 3,0,1
        step(); bus.rd_bank = 1'b0; bus.row_len = 8'd4; bus.start = 1'b1;
        idle(4);
        step(); bus.need = 1'b1;
        step(); bus.need = 1'b1;
        @(negedge clk) chk("wrap_c6", int'(bus.row_wrap), 1);
        step(); bus.need = 1'b1;
        @(negedge clk) chk("wrap_c7", int'(bus.row_wrap), 0);
        chk("burst_a3", int'(bus.mem_data), 42);
        step();
        @(negedge clk) chk("burst_a0", int'(bus.mem_data), 5);
        step();
        @(negedge clk) chk("burst_a1", int'(bus.mem_data), 8'hFD);

        // Stop together with a pending need, then restart
        step(); bus.need = 1'b1;
        step(); bus.need = 1'b1; bus.stop = 1'b1;
        step();
        @(negedge clk) chk("stop_busy", int'(bus.busy), 0);
        chk("stop_hold", int'(bus.mem_data), 8'hFD);
        step(); bus.rd_bank = 1'b0; bus.row_len = 8'd4; bus.start = 1'b1;
        step();
        step();
        @(negedge clk) chk("restart_a0", int'(bus.mem_data), 5);
        step(); bus.stop = 1'b1;
        step();

        // Ping-pong: serve bank1 while writing bank0, same-address bank1 write
        step(); bus.rd_bank = 1'b1; bus.row_len = 8'd8; bus.start = 1'b1; wr_bank0();
        for (int k = 1; k <= 4; k++) begin step(); wr_bank0(); end
        step(); bus.need = 1'b1; wr_bank0();
        step(); bus.wr_en = 1'b1; bus.wr_bank = 1'b1; bus.wr_addr = 7'd3; bus.wr_data = 8'h22;
        step(); wr_bank0();
        @(negedge clk) chk("pingpong_old", int'(bus.mem_data), 8'h11);
        for (int k = 0; k < 6; k++) begin step(); wr_bank0(); bus.need = k[0]; end
        step(); bus.stop = 1'b1;
        step();

        // Asynchronous reset during PRIME
        step(); bus.rd_bank = 1'b0; bus.row_len = 8'd16; bus.start = 1'b1;
        step();
        step();
        #1 resetn = 1'b0;
        #1 chk("rst_now_en", int'(bus.mem_en), 0);
        chk("rst_now_busy", int'(bus.busy), 0);
        chk("rst_now_data", int'(bus.mem_data), 0);
        step(); bus.need = 1'b1;
        step();
        #1 resetn = 1'b1;
        step(); bus.need = 1'b1;
        step(); bus.need = 1'b1;
        step();
        @(negedge clk) chk("post_rst_busy", int'(bus.busy), 0);
        chk("post_rst_data", int'(bus.mem_data), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            bus.wr_en   = $urandom_range(0, 1) == 1;
            bus.wr_bank = 1'($urandom);
            bus.wr_addr = AW'($urandom);
            bus.wr_data = DW'($urandom);
            bus.rd_bank = 1'($urandom);
            bus.row_len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(1, 6));
            bus.start   = $urandom_range(0, 7) == 0;
            bus.stop    = $urandom_range(0, 31) == 0;
            bus.need    = $urandom_range(0, 1) == 1;
        end
        step();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/row_mem_feeder.md
# row_mem_feeder

Double-banked row buffer that sits on the supply side of the NPU MAC core and answers its data-request protocol. The AXI-side loader writes one row into one bank while the other bank is read. After `start`, the block primes the MAC with a fixed number of enable-qualified words. It then returns one word per single-cycle `need` request, two cycles after the request. One instance serves the input-activation stream; a second instance, with `mem_en` left unconnected, serves the weight stream.

## Interface
Parameters:
- DATA_BW, 8, word width; signed 8-bit activation or weight.
- ADDR_W, 7, bank address width; bank depth is 2^ADDR_W words.
- PRIME_CNT, 3, number of words pushed during priming; must equal the MAC kernel window.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write strobe from the loader.
- wr_bank  in  1  bank selected for writing.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_BW  write data.
- start  in  1  begin serving; sampled in IDLE only.
- rd_bank  in  1  bank to read; latched on an accepted `start`.
- row_len  in  ADDR_W+1  words in the row; legal range 1..2^ADDR_W.
- stop  in  1  abort to IDLE; highest priority.
- need  in  1  one-word request from the MAC (`ia_need` or `weight_need`).
- mem_data  out  DATA_BW  registered read data (to `*_row_mem_data`).
- mem_en  out  1  read strobe; high only while priming (to `ia_row_mem_en`).
- row_wrap  out  1  one-cycle pulse on the read that uses the address row_len-1.
- busy  out  1  high when state is not IDLE.

## Operation
- Storage: two banks of 2^ADDR_W x DATA_BW, each with synchronous read and a registered output.
- Write port: always active, in every state.
- Same-bank, same-address read and write in one cycle: the read is read-first and returns the old word.
- Read pointer `rd_ptr`: reset to 0 on an accepted start.
  - Each read uses `rd_ptr`, then increments it.
  - A read at row_len-1 wraps `rd_ptr` to 0 and pulses `row_wrap` in the same cycle as that read.
- States:
  - IDLE.
    - `start`=1 and row_len!=0: latch `rd_bank` and `row_len`, set rd_ptr=0, go to PRIME.
    - `start` with row_len=0 is ignored.
  - PRIME: issue a read every cycle with `mem_en`=1 for PRIME_CNT consecutive cycles, then go to SERVE. `need` is ignored.
  - SERVE: `need` sampled high in cycle n causes a read in cycle n+1. Back-to-back `need` gives back-to-back reads. `start` is ignored.
  - Any state: `stop`=1 forces IDLE on the next edge. It wins over `start` and `need`.
    - Reads pending from an earlier `need` are dropped.
    - `mem_data` keeps its last value.
- `mem_data` changes only on a read. It is held otherwise, including in IDLE.
- row_len > 2^ADDR_W: treated as 2^ADDR_W.

## Timing
- Reset values: mem_data=0, mem_en=0, row_wrap=0, busy=0, state=IDLE, rd_ptr=0, need pipeline cleared. Bank contents are not reset.
- Priming, with `start` high in cycle 0:
  - mem_en=1 in cycles 1..PRIME_CNT, reading addresses 0..PRIME_CNT-1.
  - mem_data = word k in cycle k+2.
  - SERVE from cycle PRIME_CNT+1, with rd_ptr=PRIME_CNT.
- Read latency: `mem_data` becomes valid one cycle after its read cycle.
  - Prime: valid in the cycle after `mem_en`, matching the MAC's one-cycle delay of `en`.
  - Serve: `need` high in cycle n gives data valid in cycle n+2 and held at least through n+2, matching the MAC's two-stage need delay.
- `busy` rises in cycle 1 after `start` and falls in the cycle after `stop` is sampled.
- Asynchronous reset in mid-operation: all outputs return to their reset values immediately, and the next `start` re-primes from address 0.

## Test plan
- Prime path:
  - Stimulus: fill bank0 addr0..2 = 5, -3, 7; row_len=16; PRIME_CNT=3; start in cycle 0.
  - Required: mem_en high in cycles 1-3; mem_data = 5, -3, 7 in cycles 2, 3, 4; busy=1 from cycle 1.
- Serve latency:
  - Stimulus: after priming, one `need` pulse in cycle 10 with bank0[3]=42.
  - Required: mem_data=42 in cycle 12 and held until the next read; mem_en stays 0.
- Burst and wrap:
  - Stimulus: row_len=4, `need` high for 3 consecutive cycles after priming.
  - Required: data at addresses 3, 0, 1 on consecutive cycles; row_wrap pulses exactly once, in the read cycle for address 3.
- Ping-pong banks:
  - Stimulus: serve from bank1 while writing bank0 every cycle, including a same-address write to bank1 concurrent with a read.
  - Required: the bank1 read returns the old word; bank0 writes never disturb the output.
- Stop and restart:
  - Stimulus: assert `stop` in the same cycle as a pending `need`.
  - Required: state is IDLE next cycle; no read for that `need`; mem_data is unchanged; a new `start` re-primes from address 0.
- Reset:
  - Stimulus: drop resetn during PRIME.
  - Required: mem_en, mem_data and busy go to 0 immediately; `need` is ignored until a new `start`.
